// File: rtl/uart_rx_frame.sv
// UART receiver with 16x oversampling, majority-vote bit sampling and a single-entry
// valid/ready holding register; parity, framing and overrun errors are sticky flags.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [DIV_W-1:0]     baud_div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  input  logic                 err_clr,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_sync1, r_sync2, r_rxd_d;
  logic [DIV_W-1:0]     r_tick_cnt;
  logic [3:0]           r_samp;
  logic [2:0]           r_bitcnt;
  logic                 r_s7, r_s8, r_maj;
  logic                 r_par_bad;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr, r_ferr, r_ovr;

  logic                 w_fall, w_tick, w_maj, w_par_exp;
  logic                 w_shift_en, w_par_en, w_commit, w_load;
  logic [DIV_W-1:0]     w_reload;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxd_d <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_rxd_d <= r_sync2;
    end
  end

  assign w_fall    = r_rxd_d & ~r_sync2;
  assign w_reload  = baud_div - DIV_W'(1);
  assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == '0);
  // Vote over ticks 7 and 8 (registered) and the live tick-9 sample.
  assign w_maj     = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
  assign w_par_exp = (^r_shift) ^ 1'(PARITY_ODD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_shift_en = 1'b0;
    w_par_en   = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      S_IDLE:   if (w_fall) w_next = S_START;
      S_START:  if (w_tick && r_samp == 4'd15) w_next = r_maj ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_tick && r_samp == 4'd15) begin
          w_shift_en = 1'b1;
          if (r_bitcnt == 3'(DATA_BITS - 1))
            w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_tick && r_samp == 4'd15) begin
          w_par_en = 1'b1;
          w_next   = S_STOP;
        end
      end
      // Stop is judged at tick 9 so the FSM is back in IDLE before the next start edge.
      S_STOP: begin
        if (w_tick && r_samp == 4'd9) begin
          w_commit = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_samp     <= '0;
      r_bitcnt   <= '0;
      r_s7       <= 1'b1;
      r_s8       <= 1'b1;
      r_maj      <= 1'b1;
      r_par_bad  <= 1'b0;
      r_shift    <= '0;
    end else if (r_state == S_IDLE) begin
      r_tick_cnt <= w_reload;
      r_samp     <= '0;
      r_bitcnt   <= '0;
      r_par_bad  <= 1'b0;
    end else begin
      if (w_tick) begin
        r_tick_cnt <= w_reload;
        r_samp     <= r_samp + 4'd1;
      end else begin
        r_tick_cnt <= r_tick_cnt - DIV_W'(1);
      end
      if (w_tick && r_samp == 4'd7) r_s7  <= r_sync2;
      if (w_tick && r_samp == 4'd8) r_s8  <= r_sync2;
      if (w_tick && r_samp == 4'd9) r_maj <= w_maj;
      if (w_shift_en) begin
        r_shift  <= {r_maj, r_shift[DATA_BITS-1:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_par_en) r_par_bad <= (r_maj != w_par_exp);
    end
  end

  // Handshake: a byte transfers on any cycle where rx_valid && rx_ready; rx_data is
  // stable while rx_valid is high, and a same-cycle commit refills the register.
  assign w_load = w_commit && (!r_valid || rx_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
      // Set has priority over a coincident clear.
      r_perr <= (w_commit && r_par_bad)             | (r_perr & ~err_clr);
      r_ferr <= (w_commit && !w_maj)                | (r_ferr & ~err_clr);
      r_ovr  <= (w_commit && r_valid && !rx_ready)  | (r_ovr  & ~err_clr);
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign overrun_err = r_ovr;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

endmodule
